// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - segment type and active-low 7-segment patterns {g,f,e,d,c,b,a}
package display_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_DASH  = 7'b0111111;
  localparam seg_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - combinational BCD digit to active-low segment decoder
module bcd_to_seg
  import display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output seg_t       seg_o
);

  // Non-BCD codes (10..15) render as a dash so a corrupt counter is visible.
  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan.sv
// rtl/bcd_display_scan.sv - multiplexed common-anode BCD scanner; option LEADING_ZERO_BLANK_EN
module bcd_display_scan
  import display_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int PRESCALE = 50000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [4*NDIG-1:0] digits_in,
  input  logic [NDIG-1:0]   dp_in,
  output logic [NDIG-1:0]   an,
  output seg_t              seg,
  output logic              dp_n,
  output logic              frame_tick
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int IDX_W = $clog2(NDIG);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [4*NDIG-1:0] snap_d_q, snap_d_d;
  logic [NDIG-1:0]   snap_dp_q, snap_dp_d;

  logic [NDIG-1:0]   an_d;
  seg_t              seg_d;
  logic              dp_n_d;
  logic              frame_tick_d;

  logic              frame_start;
  logic [3:0]        cur_digit;
  logic              cur_dp;
  logic              lz_blank;
  seg_t              dec_seg;

  assign frame_start = enable && (cnt_q == '0) && (idx_q == '0);

  // Select the snapshot digit and decimal point for the active slot.
  always_comb begin
    cur_digit = 4'd0;
    cur_dp    = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if (IDX_W'(k) == idx_q) begin
        cur_digit = snap_d_q[4*k +: 4];
        cur_dp    = snap_dp_q[k];
      end
    end
  end

  bcd_to_seg u_dec (
    .bcd_i (cur_digit),
    .seg_o (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic lz_all_zero;

  // A slot is blanked when its digit and every more-significant digit are zero; slot 0 always shows.
  always_comb begin
    lz_blank    = 1'b0;
    lz_all_zero = 1'b1;
    for (int k = NDIG - 1; k >= 1; k--) begin
      lz_all_zero = lz_all_zero && (snap_d_q[4*k +: 4] == 4'd0);
      if (IDX_W'(k) == idx_q) lz_blank = lz_all_zero;
    end
  end
`else
  assign lz_blank = 1'b0;
`endif

  // Prescaler, slot index and once-per-frame snapshot; everything holds while disabled.
  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    snap_d_d  = snap_d_q;
    snap_dp_d = snap_dp_q;
    if (enable) begin
      if (frame_start) begin
        snap_d_d  = digits_in;
        snap_dp_d = dp_in;
      end
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Output next-state: the cnt==0 cycle of every slot is dark to avoid ghosting between digits.
  always_comb begin
    an_d         = '1;
    seg_d        = SEG_BLANK;
    dp_n_d       = 1'b1;
    frame_tick_d = frame_start;
    if (enable && (cnt_q != '0) && !lz_blank) begin
      an_d   = ~(NDIG'(1) << idx_q);
      seg_d  = dec_seg;
      dp_n_d = ~cur_dp;
    end
  end

  // Scan state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      snap_d_q  <= '0;
      snap_dp_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      snap_d_q  <= snap_d_d;
      snap_dp_q <= snap_dp_d;
    end
  end

  // Registered pin drivers, one cycle behind the scan state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an         <= '1;
      seg        <= SEG_BLANK;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_d;
      seg        <= seg_d;
      dp_n       <= dp_n_d;
      frame_tick <= frame_tick_d;
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// tb/tb_bcd_display_scan.sv - scoreboard bench for bcd_display_scan (NDIG=4, PRESCALE=4)
module tb_bcd_display_scan;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame_tick;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp_n;
    logic       ft;
  } exp_t;

  exp_t sb[$];

  int          m_cnt;
  int          m_idx;
  logic [15:0] m_snap;
  logic [3:0]  m_dp;

  logic [3:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic        o_ft;

  bcd_display_scan #(.NDIG(4), .PRESCALE(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .an         (an),
    .seg        (seg),
    .dp_n       (dp_n),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic ref_lz(input int i, input logic [15:0] s);
`ifdef LEADING_ZERO_BLANK_EN
    logic z;
    z = 1'b1;
    if (i == 0) return 1'b0;
    for (int j = i; j < 4; j++) if (s[4*j +: 4] != 4'd0) z = 1'b0;
    return z;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_idx  = 0;
    m_snap = '0;
    m_dp   = '0;
  endtask

  task automatic step();
    exp_t e;
    exp_t g;
    e = '{an: 4'hF, seg: 7'h7F, dp_n: 1'b1, ft: 1'b0};
    if (reset_n && enable) begin
      e.ft = (m_cnt == 0 && m_idx == 0);
      if (m_cnt != 0 && !ref_lz(m_idx, m_snap)) begin
        e.an   = ~(4'b0001 << m_idx);
        e.seg  = ref_seg(m_snap[4*m_idx +: 4]);
        e.dp_n = ~m_dp[m_idx];
      end
    end
    sb.push_back(e);
    if (!reset_n) begin
      model_reset();
    end else if (enable) begin
      if (m_cnt == 0 && m_idx == 0) begin
        m_snap = digits_in;
        m_dp   = dp_in;
      end
      if (m_cnt == 3) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    o_an  = an;
    o_seg = seg;
    o_dp  = dp_n;
    o_ft  = frame_tick;
    g = sb.pop_front();
    chk("sb_an",  {12'd0, o_an},  {12'd0, g.an});
    chk("sb_seg", {9'd0,  o_seg}, {9'd0,  g.seg});
    chk("sb_dp",  {15'd0, o_dp},  {15'd0, g.dp_n});
    chk("sb_ft",  {15'd0, o_ft},  {15'd0, g.ft});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b0;
    digits_in = 16'h1234;
    dp_in     = 4'b0000;
    model_reset();

    run(5);
    chk("reset_an",  {12'd0, o_an},  16'h000F);
    chk("reset_seg", {9'd0,  o_seg}, 16'h007F);
    chk("reset_dp",  {15'd0, o_dp},  16'h0001);
    chk("reset_ft",  {15'd0, o_ft},  16'h0000);

    reset_n = 1'b1;
    enable  = 1'b1;
    run(1);
    chk("first_tick", {15'd0, o_ft}, 16'h0001);
    chk("first_dark", {12'd0, o_an}, 16'h000F);
    run(1);
    chk("slot0_an",  {12'd0, o_an},  16'h000E);
    chk("slot0_seg", {9'd0,  o_seg}, 16'h0019);
    run(11);
    run(1);
    chk("slot3_an",  {12'd0, o_an},  16'h0007);
    chk("slot3_seg", {9'd0,  o_seg}, 16'h0079);
    run(2);
    run(1);
    chk("tick_16", {15'd0, o_ft}, 16'h0001);

    run(3);
    digits_in = 16'h5678;
    run(10);
    chk("snap_hold_seg", {9'd0, o_seg}, 16'h0079);
    run(2);
    run(1);
    chk("tick_32", {15'd0, o_ft}, 16'h0001);
    digits_in = 16'h1A34;
    dp_in     = 4'b0100;
    run(12);
    run(1);
    chk("snap_new_seg", {9'd0, o_seg}, 16'h0012);

    run(11);
    run(1);
    chk("dash_seg", {9'd0,  o_seg}, 16'h003F);
    chk("dash_dp",  {15'd0, o_dp},  16'h0000);
    chk("dash_an",  {12'd0, o_an},  16'h000B);

    digits_in = 16'h0030;
    dp_in     = 4'b0000;
    run(6);
    run(1);
    run(1);
    chk("lz_slot0_an",  {12'd0, o_an},  16'h000E);
    chk("lz_slot0_seg", {9'd0,  o_seg}, 16'h0040);
    run(11);
    run(1);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz_slot3_an", {12'd0, o_an}, 16'h000F);
`else
    chk("lz_slot3_an",  {12'd0, o_an},  16'h0007);
    chk("lz_slot3_seg", {9'd0,  o_seg}, 16'h0040);
`endif

    run(8);
    enable = 1'b0;
    run(1);
    chk("dis_an", {12'd0, o_an}, 16'h000F);
    chk("dis_ft", {15'd0, o_ft}, 16'h0000);
    run(9);
    enable = 1'b1;
    run(1);
    chk("resume_an",  {12'd0, o_an},  16'h000D);
    chk("resume_seg", {9'd0,  o_seg}, 16'h0030);

    #3;
    reset_n = 1'b0;
    #1;
    chk("async_an",  {12'd0, an},         16'h000F);
    chk("async_seg", {9'd0,  seg},        16'h007F);
    chk("async_dp",  {15'd0, dp_n},       16'h0001);
    chk("async_ft",  {15'd0, frame_tick}, 16'h0000);
    model_reset();
    run(2);
    reset_n   = 1'b1;
    digits_in = 16'h9087;
    dp_in     = 4'b0001;
    run(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
